// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit per clock, LSB first.
// An operation is accepted in IDLE, runs for WIDTH cycles through a single
// 1-bit add/sub cell with a registered carry/borrow, then waits in DONE
// until the consumer takes the result.
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add the signed overflow
// output ovf.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | in_ready=1, waiting for in_valid
// RUN     | one operand bit per cycle through the cell, WIDTH cycles
// DONE    | out_valid=1, result held until out_ready
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_a;
  logic bit_b;
  logic sum_bit;
  logic carry_nxt;

  // Single 1-bit add/sub cell; the operand shift registers present the
  // current bit in position 0.
  always_comb begin
    bit_a   = a_q[0];
    bit_b   = b_q[0];
    sum_bit = bit_a ^ bit_b ^ carry_q;
    if (sub_q) begin
      carry_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & carry_q);
    end else begin
      carry_nxt = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          sub_d    = op_sub;
          carry_d  = cin;
          cnt_d    = '0;
          result_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        carry_d         = carry_nxt;
        result_d[cnt_q] = sum_bit;
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          carry_out_d = carry_nxt;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry_q is the carry/borrow into the MSB here.
          ovf_d       = carry_q ^ carry_nxt;
`endif
        end
      end
      ST_DONE: begin
        // No new accept here even with out_ready; IDLE must be visited first.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (WIDTH=8): directed literal cases, backpressure,
// mid-operation reset and random operations against an arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic, busy/done flags, edge count.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_edges = 0;
  logic [W-1:0] m_res = '0;
  logic         m_co = 1'b0;
  logic         m_ovf = 1'b0;

  task automatic model_accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic sv, input logic cv);
    logic [W:0] t;
    int sr;
    if (!sv) begin
      t  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      sr = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    end else begin
      t  = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      sr = int'($signed(av)) - int'($signed(bv)) - int'(cv);
    end
    m_res = t[W-1:0];
    m_co  = t[W];
    m_ovf = (sr > 127) || (sr < -128);
  endtask

  // Compare process: check outputs on every falling edge, then predict the
  // effect of the next rising edge from the inputs now applied.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_result", {24'b0, result}, 32'd0);
      check("rst_carry_out", {31'b0, carry_out}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      check("mon_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      check("mon_out_valid", {31'b0, out_valid}, {31'b0, m_done});
      if (m_done) begin
        check("mon_result", {24'b0, result}, {24'b0, m_res});
        check("mon_carry_out", {31'b0, carry_out}, {31'b0, m_co});
`ifdef SERIAL_ADDSUB_OVF_EN
        check("mon_ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
      end
      if (!m_busy) begin
        if (in_valid) begin
          model_accept(a, b, op_sub, cin);
          m_busy  = 1'b1;
          m_edges = 0;
        end
      end else if (m_done) begin
        if (out_ready) begin
          m_busy = 1'b0;
          m_done = 1'b0;
        end
      end else begin
        m_edges++;
        if (m_edges == W) m_done = 1'b1;
      end
    end
  end

  // Runs one operation from posedge+1 context; returns observed values.
  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic sub_i, input logic cin_i, input int hold,
                        output logic [W-1:0] r_o, output logic c_o,
                        output logic v_o, output int lat_o);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wait_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = a_i; b = b_i; op_sub = sub_i; cin = cin_i;
    @(posedge clk); #1;
    check("accepted", {31'b0, in_ready}, 32'd0);
    lat_o = 0;
    while (!out_valid && lat_o < 40) begin
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      op_sub    = 1'($urandom);
      cin       = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat_o++;
    end
    r_o = result;
    c_o = carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
    v_o = ovf;
`else
    v_o = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_result", {24'b0, result}, {24'b0, r_o});
      check("bp_carry_out", {31'b0, carry_out}, {31'b0, c_o});
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b1; a = 8'h0F; b = 8'h01;
    op_sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first operation taken on the first edge after reset release
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, r, c, v, lat);
    check("add_0f_01_res", {24'b0, r}, 32'h10);
    check("add_0f_01_co", {31'b0, c}, 32'd0);
    check("add_0f_01_lat", lat, 32'd8);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, r, c, v, lat);
    check("add_ff_01_res", {24'b0, r}, 32'h00);
    check("add_ff_01_co", {31'b0, c}, 32'd1);

    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 0, r, c, v, lat);
    check("add_ff_01_c1_res", {24'b0, r}, 32'h01);
    check("add_ff_01_c1_co", {31'b0, c}, 32'd1);

    run_op(8'h05, 8'h07, 1'b1, 1'b0, 2, r, c, v, lat);
    check("sub_05_07_res", {24'b0, r}, 32'hFE);
    check("sub_05_07_bo", {31'b0, c}, 32'd1);

    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0, r, c, v, lat);
    check("sub_07_05_b1_res", {24'b0, r}, 32'h01);
    check("sub_07_05_b1_bo", {31'b0, c}, 32'd0);

    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0, r, c, v, lat);
    check("sub_80_01_res", {24'b0, r}, 32'h7F);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("sub_80_01_ovf", {31'b0, v}, 32'd1);
`endif
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, r, c, v, lat);
    check("add_7f_01_res", {24'b0, r}, 32'h80);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("add_7f_01_ovf", {31'b0, v}, 32'd1);
`endif
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, r, c, v, lat);
    check("add_01_01_res", {24'b0, r}, 32'h02);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("add_01_01_ovf", {31'b0, v}, 32'd0);
`endif

    // backpressure: 5 cycles of out_ready=0 in DONE
    run_op(8'hA5, 8'h3C, 1'b0, 1'b0, 5, r, c, v, lat);
    check("bp_case_res", {24'b0, r}, 32'hE1);
    check("bp_case_co", {31'b0, c}, 32'd0);

    // reset pulsed in the 3rd RUN cycle
    in_valid = 1'b1; a = 8'hFF; b = 8'h00; op_sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_result", {24'b0, result}, 32'd0);
    check("midrst_carry_out", {31'b0, carry_out}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op(8'h3C, 8'h0F, 1'b1, 1'b0, 0, r, c, v, lat);
    check("post_rst_res", {24'b0, r}, 32'h2D);
    check("post_rst_bo", {31'b0, c}, 32'd0);
    check("post_rst_lat", lat, 32'd8);

    // random operations; the compare process checks every result
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), r, c, v, lat);
      check("rand_lat", lat, 32'd8);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operands and op are valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-007 The block SHALL have port op_sub, input, 1: 0 = a+b+cin, 1 = a-b-cin.
REQ-008 The block SHALL have port cin, input, 1, initial carry (add) or borrow (sub).
REQ-009 The block SHALL have port out_valid, output, 1, result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH, sum or difference.
REQ-012 The block SHALL have port carry_out, output, 1, final carry (add) or final borrow (sub).

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 On an edge with in_valid=1 in IDLE, the block SHALL latch a, b, op_sub and cin, clear the bit counter, and enter RUN.
REQ-016 In RUN, each cycle SHALL process exactly one bit, LSB first, through one 1-bit adder/subtractor cell and a registered carry/borrow flop.
REQ-017 For add, each bit SHALL compute s=a^b^c and c'=(a&b)|(c&(a^b)).
REQ-018 For subtract, each bit SHALL compute d=a^b^w and w'=(~a&b)|(~(a^b)&w).
REQ-019 Each result bit SHALL be shifted into the result register at its bit position.
REQ-020 After WIDTH RUN cycles, the FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-021 In DONE, out_valid SHALL be 1, and result and carry_out SHALL be held stable until out_ready=1.
REQ-022 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE and deassert out_valid.
REQ-023 result and carry_out SHALL be don't-care except when out_valid=1.
REQ-024 Throughput SHALL be one operation per WIDTH+2 cycles at most; no new operation SHALL be accepted in DONE, even if out_ready=1.
REQ-025 Input changes during RUN or DONE SHALL have no effect.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; the overflow bit SHALL be reported only via carry_out.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state to IDLE, the bit counter to 0, the carry flop to 0, result to 0, carry_out to 0 and out_valid to 0 (and ovf to 0 when built).
REQ-028 Reset asserted during RUN or DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-029 The first operation SHALL be accepted on the first clk edge after rst_n deasserts, provided in_valid=1.

Configuration
REQ-030 When the macro SERIAL_ADDSUB_OVF_EN is defined, the block SHALL add output ovf (1 bit), the signed two's-complement overflow, equal to (carry/borrow into MSB) XOR (carry/borrow out of MSB); it SHALL be valid and held with out_valid.
REQ-031 When SERIAL_ADDSUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification (WIDTH=8)
REQ-032 The bench SHALL check: add, a=0x0F, b=0x01, cin=0 -> result=0x10, carry_out=0, out_valid exactly 8 cycles after accept.
REQ-033 The bench SHALL check: add, a=0xFF, b=0x01, cin=0 -> result=0x00, carry_out=1; with cin=1 -> result=0x01, carry_out=1.
REQ-034 The bench SHALL check: sub, a=0x05, b=0x07, cin=0 -> result=0xFE, carry_out=1; a=0x07, b=0x05, cin=1 -> result=0x01, carry_out=0.
REQ-035 The bench SHALL check, with OVF_EN defined: sub, 0x80-0x01 -> result=0x7F, ovf=1; add, 0x7F+0x01 -> result=0x80, ovf=1; add, 0x01+0x01 -> ovf=0.
REQ-036 The bench SHALL check backpressure: out_ready held 0 for 5 cycles in DONE -> result stable, out_valid=1, in_ready=0 throughout; return to IDLE one edge after out_ready=1.
REQ-037 The bench SHALL check reset mid-operation: rst_n pulsed low at the 3rd RUN cycle -> outputs zero immediately, in_ready=1, no out_valid; next operation correct.
